buffer_reader: RTL and testbench

Sequential read engine that sits directly downstream of the 2-port `buffer` memory in the RNN datapath. On a `start` command it walks a contiguous address range of the buffer, beginning at `base`, and streams the words out over a valid/ready interface. It stalls cleanly under backpressure and signals completion with a one-cycle `done` pulse. It drives the buffer's address port and consumes its combinational read data; it never writes the buffer.

---
 rtl/buffer_reader_if.sv | 12 +
 rtl/buffer_reader.sv | 98 +++++++++
 tb/tb_buffer_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/buffer_reader_if.sv
// rtl/buffer_reader_if.sv - output word stream between buffer_reader and its consumer
interface buffer_reader_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [WORD_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/buffer_reader.sv
// rtl/buffer_reader.sv - walks a contiguous range of the buffer and streams the words out
// The first word loads as SETTLE ends, so buf_q is sampled only after the settle cycle.
module buffer_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] buf_a_o,
    input  logic [WORD_WIDTH-1:0] buf_q_i,
    buffer_reader_if.master       m_if
);

    typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] buf_a_q, buf_a_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  m_valid_q, m_valid_d;
    logic [WORD_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  load;

    assign load = ((state_q == SETTLE) || (state_q == STREAM))
                  && (remaining_q != '0)
                  && (!m_valid_q || m_if.m_ready);

    always_comb begin
        state_d     = state_q;
        buf_a_d     = buf_a_q;
        remaining_d = remaining_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    buf_a_d     = base_i;
                    remaining_d = len_i;
                    state_d     = SETTLE;
                end
            end
            SETTLE:  state_d = (remaining_q == '0) ? DONE : STREAM;
            STREAM: begin
                if (m_valid_q && m_if.m_ready && m_last_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh word replaces the accepted one in the same cycle (no bubble).
        if (load) begin
            m_data_d    = buf_q_i;
            m_valid_d   = 1'b1;
            m_last_d    = (remaining_q == LEN_WIDTH'(1));
            buf_a_d     = buf_a_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
        end else if (m_valid_q && m_if.m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_a_q     <= '0;
            remaining_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_a_q     <= buf_a_d;
            remaining_q <= remaining_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign buf_a_o      = buf_a_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign m_if.m_last  = m_last_q;

endmodule

// File: tb/tb_buffer_reader.sv
// tb/tb_buffer_reader.sv - directed bench for buffer_reader with a buffer model
module tb_buffer_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [9:0]  buf_a;
    logic [7:0]  buf_q;

    logic        init;
    logic        we;
    logic [9:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  mem [1024];

    int errors = 0;
    int checks = 0;

    buffer_reader_if #(.WORD_WIDTH(8)) s_if ();

    buffer_reader #(.ADDR_WIDTH(10), .WORD_WIDTH(8), .LEN_WIDTH(11)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .base_i  (base),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .buf_a_o (buf_a),
        .buf_q_i (buf_q),
        .m_if    (s_if)
    );

    always #5 clk = ~clk;

    // Buffer model: buffer[i] = i after init; writes land on the edge where we is high.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
    assign buf_q = mem[buf_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues start at the current negedge (cycle 0) and scoreboards the transfer.
    task automatic run(input int b, input int n, input bit toggle, input int exp_done_cyc);
        int         cyc = 0;
        int         got = 0;
        int         dones = 0;
        int         done_cyc = -1;
        bit         stalled = 1'b0;
        logic [7:0] prev = '0;
        start = 1'b1; base = 10'(b); len = 11'(n); s_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (dones == 0 && cyc < 200) begin
            if (toggle) s_if.m_ready = (cyc % 3 == 2);
            if (stalled) begin
                chk("stall_valid", 32'(s_if.m_valid), 32'd1);
                chk("stall_data", 32'(s_if.m_data), 32'(prev));
            end
            if (s_if.m_valid && s_if.m_ready) begin
                chk("beat_data", 32'(s_if.m_data), 32'(((b + got) % 1024) % 256));
                chk("beat_last", 32'(s_if.m_last), 32'(got == n - 1));
                got++;
            end
            stalled = s_if.m_valid && !s_if.m_ready;
            prev    = s_if.m_data;
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", 32'(got), 32'(n));
        chk("done_seen", 32'(dones), 32'd1);
        if (exp_done_cyc != 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        s_if.m_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b1; start = 1'b0; base = '0; len = '0;
        we = 1'b0; wa = '0; wd = '0; s_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; init = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(s_if.m_valid), 32'd0);
        chk("rst_data", 32'(s_if.m_data), 32'd0);
        chk("rst_last", 32'(s_if.m_last), 32'd0);
        chk("rst_addr", 32'(buf_a), 32'd0);

        // base 5, len 4, ready high: words 5..8 in cycles 2..5, done in cycle 6
        run(5, 4, 1'b0, 6);
        chk("addr_hold", 32'(buf_a), 32'd9);

        // address wrap 1022, 1023, 0, 1
        run(1022, 4, 1'b0, 6);

        // backpressure pattern 1,0,0,...
        run(10, 6, 1'b1, 0);

        // len = 0
        s_if.m_ready = 1'b1;
        start = 1'b1; base = 10'd50; len = 11'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_c1_busy", 32'(busy), 32'd1);
        chk("len0_c1_valid", 32'(s_if.m_valid), 32'd0);
        chk("len0_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("len0_c2_done", 32'(done), 32'd1);
        chk("len0_c2_busy", 32'(busy), 32'd1);
        chk("len0_c2_valid", 32'(s_if.m_valid), 32'd0);
        @(negedge clk);
        chk("len0_c3_done", 32'(done), 32'd0);
        chk("len0_c3_busy", 32'(busy), 32'd0);

        // write in the cycle before start must be visible
        we = 1'b1; wa = 10'd3; wd = 8'hAA;
        @(negedge clk);
        we = 1'b0;
        start = 1'b1; base = 10'd3; len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        chk("wr_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_c2_valid", 32'(s_if.m_valid), 32'd1);
        chk("wr_c2_data", 32'(s_if.m_data), 32'hAA);
        chk("wr_c2_last", 32'(s_if.m_last), 32'd1);
        @(negedge clk);
        chk("wr_c3_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("wr_c4_busy", 32'(busy), 32'd0);

        // reset after 2 of 5 beats
        start = 1'b1; base = 10'd20; len = 11'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rs_beat0", 32'(s_if.m_data), 32'd20);
        @(negedge clk);
        chk("rs_beat1", 32'(s_if.m_data), 32'd21);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_valid", 32'(s_if.m_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_addr", 32'(buf_a), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rs_no_done", 32'(done), 32'd0);
        run(40, 3, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
